fsm_share_ctrl_amisha: RTL and testbench

FSM_SHARE_CTRL_AMISHA -- requirements
Module: fsm_share_ctrl_amisha

---
 rtl/fsm_share_ctrl_amisha.sv | 149 ++++++++++++++
 tb/tb_fsm_share_ctrl_amisha.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_share_ctrl_amisha.sv
// Round-robin arbiter driving a shared a/b FSM on behalf of four requesters.
// Each grant runs a short (s0->s2->s0) or long (s0->s1->s0) a/b sequence and checks the y responses.
module fsm_share_ctrl_amisha #(
  parameter int DWELL_W = 4
) (
  input  logic                   clk_amisha,
  input  logic                   reset_amisha,
  input  logic [3:0]             req_amisha,
  input  logic [3:0]             mode_amisha,
  input  logic [4*DWELL_W-1:0]   dwell_amisha,
  output logic [3:0]             gnt_amisha,
  output logic [3:0]             done_amisha,
  output logic                   a_out_amisha,
  output logic                   b_out_amisha,
  input  logic                   y0_in_amisha,
  input  logic                   y1_in_amisha,
  output logic                   busy_amisha,
  output logic                   err_amisha
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SHORT_ISSUE = 3'd1,
    SHORT_RECOV = 3'd2,
    LONG_ENTER  = 3'd3,
    LONG_DWELL  = 3'd4,
    LONG_EXIT   = 3'd5,
    DONE        = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [3:0]           gnt_q, gnt_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [1:0]           win;
  logic                 grant;

  // First requesting index found scanning upward from ptr+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign win   = rr_pick(req_amisha, ptr_q);
  assign grant = (state_q == IDLE) && (|req_amisha);

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:        state_d = grant ? (mode_amisha[win] ? LONG_ENTER : SHORT_ISSUE) : IDLE;
      SHORT_ISSUE: state_d = SHORT_RECOV;
      SHORT_RECOV: state_d = DONE;
      LONG_ENTER:  state_d = (dwell_q == '0) ? LONG_EXIT : LONG_DWELL;
      LONG_DWELL:  state_d = (cnt_q == DWELL_W'(1)) ? LONG_EXIT : LONG_DWELL;
      LONG_EXIT:   state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    a_out_amisha = 1'b0;
    b_out_amisha = 1'b0;
    done_amisha  = 4'b0000;
    case (state_q)
      SHORT_ISSUE: begin
        a_out_amisha = 1'b1;
        b_out_amisha = 1'b1;
      end
      LONG_ENTER, LONG_EXIT: a_out_amisha = 1'b1;
      DONE:                  done_amisha  = gnt_q;
      default: ;
    endcase
  end

  assign busy_amisha = (state_q != IDLE);
  assign gnt_amisha  = gnt_q;
  assign err_amisha  = err_q;

  // Grant, counter and error bookkeeping alongside the state walk.
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d   = win;
          gnt_d   = 4'b0001 << win;
          mode_d  = mode_amisha[win];
          dwell_d = dwell_amisha[int'(win)*DWELL_W +: DWELL_W];
        end
      end
      SHORT_ISSUE: if (!y0_in_amisha) err_d = 1'b1;
      SHORT_RECOV: if (y1_in_amisha)  err_d = 1'b1;
      LONG_ENTER:  cnt_d = dwell_q;
      LONG_DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        if (!y1_in_amisha) err_d = 1'b1;
      end
      LONG_EXIT:   if (!y1_in_amisha) err_d = 1'b1;
      DONE:        gnt_d = 4'b0000;
      default:     gnt_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      ptr_q <= 2'd3;
      gnt_q <= 4'b0000;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // The latched op parameters are only read after a grant has loaded them.
  always_ff @(posedge clk_amisha) begin
    mode_q  <= mode_d;
    dwell_q <= dwell_d;
  end

endmodule

// File: tb/tb_fsm_share_ctrl_amisha.sv
// Bench for fsm_share_ctrl_amisha: vector table, directed corner sequences and a random run
// checked every cycle against a transaction-level schedule model.
module tb_fsm_share_ctrl_amisha;

  logic        clk;
  logic        reset;
  logic [3:0]  req, mode;
  logic [15:0] dwell;
  logic [3:0]  gnt, done;
  logic        a_o, b_o, y0, y1, busy, err;

  fsm_share_ctrl_amisha #(.DWELL_W(4)) dut (
    .clk_amisha   (clk),
    .reset_amisha (reset),
    .req_amisha   (req),
    .mode_amisha  (mode),
    .dwell_amisha (dwell),
    .gnt_amisha   (gnt),
    .done_amisha  (done),
    .a_out_amisha (a_o),
    .b_out_amisha (b_o),
    .y0_in_amisha (y0),
    .y1_in_amisha (y1),
    .busy_amisha  (busy),
    .err_amisha   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // yk: which y response the cycle expects (0 none, 1 y0 high, 2 y1 low, 3 y1 high)
  typedef struct {
    logic a;
    logic b;
    logic dn;
    int   yk;
  } rec_t;

  rec_t       sched[$];
  logic [3:0] m_gnt;
  int         m_ptr;
  logic       m_err;
  logic       inj;

  function automatic logic [11:0] outs();
    return {gnt, done, a_o, b_o, busy, err};
  endfunction

  function automatic logic [11:0] model_outs();
    rec_t c;
    if (sched.size() == 0) return {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, m_err};
    c = sched[0];
    return {m_gnt, (c.dn ? m_gnt : 4'b0), c.a, c.b, 1'b1, m_err};
  endfunction

  task automatic model_reset();
    sched.delete();
    m_gnt = 4'b0;
    m_ptr = 3;
    m_err = 1'b0;
  endtask

  // One clock: respond on y as the shared FSM would, advance the model, compare after the edge.
  task automatic step();
    rec_t cur;
    rec_t r;
    int   idx;
    int   d;
    cur = '{a: 1'b0, b: 1'b0, dn: 1'b0, yk: 0};
    if (sched.size() > 0) cur = sched[0];
    y0 = 1'b1;
    y1 = (cur.yk == 3);
    if (cur.yk == 0) begin
      y0 = 1'($urandom);
      y1 = 1'($urandom);
    end
    if (inj) begin
      if (cur.yk == 1)      y0 = 1'b0;
      else if (cur.yk == 2) y1 = 1'b1;
      else if (cur.yk == 3) y1 = 1'b0;
    end
    if ((cur.yk == 1 && !y0) || (cur.yk == 2 && y1) || (cur.yk == 3 && !y1)) m_err = 1'b1;
    if (sched.size() > 0) begin
      void'(sched.pop_front());
      if (sched.size() == 0) m_gnt = 4'b0;
    end else if (req != 4'b0) begin
      idx = m_ptr;
      for (int k = 1; k <= 4; k++) begin
        if (req[(m_ptr + k) % 4]) begin
          idx = (m_ptr + k) % 4;
          break;
        end
      end
      m_ptr = idx;
      m_gnt = 4'(1 << idx);
      if (mode[idx]) begin
        d = int'(dwell[idx*4 +: 4]);
        r = '{a: 1'b1, b: 1'b0, dn: 1'b0, yk: 0}; sched.push_back(r);
        for (int j = 0; j < d; j++) begin
          r = '{a: 1'b0, b: 1'b0, dn: 1'b0, yk: 3}; sched.push_back(r);
        end
        r = '{a: 1'b1, b: 1'b0, dn: 1'b0, yk: 3}; sched.push_back(r);
      end else begin
        r = '{a: 1'b1, b: 1'b1, dn: 1'b0, yk: 1}; sched.push_back(r);
        r = '{a: 1'b0, b: 1'b0, dn: 1'b0, yk: 2}; sched.push_back(r);
      end
      r = '{a: 1'b0, b: 1'b0, dn: 1'b1, yk: 0}; sched.push_back(r);
    end
    @(posedge clk);
    #1;
    chk("cycle_outputs", 32'(outs()), 32'(model_outs()));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("reset_outputs_zero", 32'(outs()), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int c = 0; c < 40 && busy; c++) step();
    chk("returned_idle", 32'(busy), 32'h0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  mode;
    logic [15:0] dwell;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_ab;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];
  int   lat;
  logic [3:0] dv;
  int   gcyc[$];
  int   gidx[$];
  logic [3:0] prev;
  int   exp_cyc[5];
  int   exp_idx[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 16'h0000, 4'b0001, 2'b11, 3};
    tbl[1] = '{4'b0100, 4'b0100, 16'h0300, 4'b0100, 2'b10, 6};
    tbl[2] = '{4'b1011, 4'b0000, 16'h0000, 4'b1000, 2'b11, 3};
    tbl[3] = '{4'b0011, 4'b0010, 16'h0000, 4'b0001, 2'b11, 3};
    tbl[4] = '{4'b0011, 4'b0010, 16'h00F0, 4'b0010, 2'b10, 18};
    tbl[5] = '{4'b1000, 4'b1000, 16'h0000, 4'b1000, 2'b10, 3};
    tbl[6] = '{4'b1111, 4'b0000, 16'h0000, 4'b0001, 2'b11, 3};
    tbl[7] = '{4'b0001, 4'b0001, 16'h0001, 4'b0001, 2'b10, 4};
    exp_cyc = '{1, 5, 9, 13, 17};
    exp_idx = '{0, 1, 2, 3, 0};

    req = 4'b0; mode = 4'b0; dwell = 16'h0; y0 = 1'b1; y1 = 1'b0; inj = 1'b0;
    model_reset();
    apply_reset();

    // Table: one request pulse each, then mode/dwell scrambled while the op runs.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; mode = tbl[i].mode; dwell = tbl[i].dwell;
      step();
      req = 4'b0; mode = ~tbl[i].mode; dwell = 16'($urandom);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_ab", i), 32'({a_o, b_o}), 32'(tbl[i].exp_ab));
      lat = -1; dv = 4'b0;
      for (int c = 1; c <= 40; c++) begin
        if (done != 4'b0 && lat < 0) begin
          lat = c;
          dv  = done;
        end
        if (!busy) break;
        step();
      end
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_done", i), 32'(dv), 32'(tbl[i].exp_gnt));
    end

    // Bad y0 in SHORT_ISSUE: err rises next cycle and survives a clean op.
    req = 4'b0001; mode = 4'b0000;
    step();
    req = 4'b0000; inj = 1'b1;
    step();
    inj = 1'b0;
    chk("err_set_after_issue", 32'(err), 32'h1);
    run_to_idle();
    req = 4'b0010;
    step();
    req = 4'b0000;
    run_to_idle();
    chk("err_sticky", 32'(err), 32'h1);

    // Reset in LONG_DWELL abandons the op; requester 1 wins first afterwards.
    req = 4'b0001; mode = 4'b0001; dwell = 16'h0005;
    step();
    req = 4'b0000;
    step();
    step();
    chk("in_long_dwell", 32'({busy, a_o, b_o}), 32'b100);
    apply_reset();
    chk("err_cleared", 32'(err), 32'h0);
    req = 4'b1010; mode = 4'b0000;
    step();
    req = 4'b0000;
    chk("post_reset_gnt", 32'(gnt), 32'b0010);
    run_to_idle();

    // All four held: strict rotation from requester 0, grants four cycles apart.
    apply_reset();
    req = 4'b1111; mode = 4'b0000;
    prev = 4'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (gnt != 4'b0 && prev == 4'b0) begin
        gcyc.push_back(c);
        for (int k = 0; k < 4; k++) if (gnt[k]) gidx.push_back(k);
      end
      prev = gnt;
    end
    req = 4'b0000;
    chk("rr_grant_count", 32'(gcyc.size()), 32'd5);
    for (int k = 0; k < 5 && k < gcyc.size() && k < gidx.size(); k++) begin
      chk($sformatf("rr%0d_cycle", k), 32'(gcyc[k]), 32'(exp_cyc[k]));
      chk($sformatf("rr%0d_index", k), 32'(gidx[k]), 32'(exp_idx[k]));
    end
    run_to_idle();

    // Random traffic, clean responses first, then occasional bad y responses.
    apply_reset();
    for (int c = 0; c < 700; c++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      mode  = 4'($urandom);
      dwell = 16'($urandom);
      inj   = (c >= 400) && ($urandom_range(0, 29) == 0);
      step();
    end
    inj = 1'b0;
    req = 4'b0;
    run_to_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
